// File: rtl/dmux.sv
// dmux: one-input, two-output demultiplexer.
// Routes din to y0 (sel=0) or y1 (sel=1) and parks the other output at
// IDLE_VALUE. Reset (async, active-low) forces both outputs to IDLE_VALUE.
// REGISTERED=0 gives a purely combinational path gated by rst_n.
// REGISTERED=1 adds a y0/y1 register pair with one cycle of latency.
module dmux #(
    parameter int                 WIDTH      = 1,
    parameter bit                 REGISTERED = 1'b0,
    parameter logic [WIDTH-1:0]   IDLE_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             sel,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1
);

    logic [WIDTH-1:0] y0_d;
    logic [WIDTH-1:0] y1_d;

    // Routing rule. An unknown select yields X on both outputs rather than
    // copying din onto both; in hardware that branch is unreachable.
    always_comb begin
        y0_d = IDLE_VALUE;
        y1_d = IDLE_VALUE;
        if (sel == 1'b0) begin
            y0_d = din;
        end else if (sel == 1'b1) begin
            y1_d = din;
        end else begin
            y0_d = 'x;
            y1_d = 'x;
        end
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] y0_q;
            logic [WIDTH-1:0] y1_q;

            // Capture the routed pair each rising edge; reset clears at once
            // and also wins over a capture on the same edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y0_q <= IDLE_VALUE;
                    y1_q <= IDLE_VALUE;
                end else begin
                    y0_q <= y0_d;
                    y1_q <= y1_d;
                end
            end

            assign y0 = y0_q;
            assign y1 = y1_q;
        end else begin : g_comb
            // No clock in this mode; tie it off so it reads as intentional.
            logic unused_clk;
            assign unused_clk = clk;

            assign y0 = rst_n ? y0_d : IDLE_VALUE;
            assign y1 = rst_n ? y1_d : IDLE_VALUE;
        end
    endgenerate

endmodule

// File: tb/tb_dmux.sv
// Scoreboard bench for dmux: four instances (default, 8-bit, 4-bit with
// idle 4'hF, 8-bit registered) share one stimulus stream.
module tb_dmux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       sel = 1'b0;

    logic       d0_y0, d0_y1;
    logic [7:0] w8_y0, w8_y1;
    logic [3:0] wf_y0, wf_y1;
    logic [7:0] rg_y0, rg_y1;

    always #5 clk = ~clk;

    dmux u_def (.clk(clk), .rst_n(rst_n), .din(din[0]), .sel(sel), .y0(d0_y0), .y1(d0_y1));
    dmux #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .y0(w8_y0), .y1(w8_y1));
    dmux #(.WIDTH(4), .IDLE_VALUE(4'hF)) u_wf (.clk(clk), .rst_n(rst_n), .din(din[3:0]), .sel(sel),
                                              .y0(wf_y0), .y1(wf_y1));
    dmux #(.WIDTH(8), .REGISTERED(1'b1)) u_rg (.clk(clk), .rst_n(rst_n), .din(din), .sel(sel),
                                              .y0(rg_y0), .y1(rg_y1));

    typedef struct packed {
        logic [7:0] y0;
        logic [7:0] y1;
    } pair_t;

    typedef struct {
        int    cyc;
        int    id;
        pair_t exp;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic       prev_rst = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       prev_s = 1'b0;

    // Reference: selected output carries din, the other sits idle; reset idles both.
    function automatic pair_t route(logic rst, logic [7:0] d, logic s,
                                    logic [7:0] idle, logic [7:0] mask);
        pair_t p;
        p.y0 = idle;
        p.y1 = idle;
        if (rst) begin
            if (s) p.y1 = d & mask;
            else   p.y0 = d & mask;
        end
        return p;
    endfunction

    always @(posedge clk) cyc++;

    task automatic push(int id, pair_t e);
        exp_t x;
        x.cyc = cyc;
        x.id  = id;
        x.exp = e;
        exp_q.push_back(x);
    endtask

    // One cycle of stimulus; pulse=1 drops rst_n briefly mid-cycle.
    task automatic step(logic rst, logic [7:0] d, logic s, bit pulse);
        logic r_now;
        @(posedge clk);
        #1;
        rst_n = rst;
        din   = d;
        sel   = s;
        r_now = rst && !pulse;
        push(0, route(r_now, d, s, 8'h00, 8'h01));
        push(1, route(r_now, d, s, 8'h00, 8'hFF));
        push(2, route(r_now, d, s, 8'h0F, 8'h0F));
        if (r_now) push(3, route(prev_rst, prev_d, prev_s, 8'h00, 8'hFF));
        else       push(3, route(1'b0, 8'h00, 1'b0, 8'h00, 8'hFF));
        prev_rst = rst;
        prev_d   = d;
        prev_s   = s;
        if (pulse && rst) begin
            #2 rst_n = 1'b0;
            #4 rst_n = 1'b1;
        end
    endtask

    // Monitor: at each falling edge compare every expectation due this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t  x;
                pair_t act;
                string nm;
                x = exp_q.pop_front();
                case (x.id)
                    0: begin act.y0 = {7'b0, d0_y0}; act.y1 = {7'b0, d0_y1}; nm = "def"; end
                    1: begin act.y0 = w8_y0; act.y1 = w8_y1; nm = "w8"; end
                    2: begin act.y0 = {4'b0, wf_y0}; act.y1 = {4'b0, wf_y1}; nm = "w4_idleF"; end
                    default: begin act.y0 = rg_y0; act.y1 = rg_y1; nm = "registered"; end
                endcase
                checks++;
                if (act !== x.exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got y0=%h y1=%h expected y0=%h y1=%h",
                             nm, x.cyc, act.y0, act.y1, x.exp.y0, x.exp.y1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // reset held, then released
        step(1'b0, 8'hFF, 1'b1, 1'b0);
        // test plan 1
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        // test plan 2: reset while din=1,sel=1, then release
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        step(1'b0, 8'hFF, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        // test plan 3/4
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        step(1'b1, 8'h03, 1'b1, 1'b0);
        step(1'b0, 8'h03, 1'b1, 1'b0);
        // test plan 5: registered latency and mid-cycle reset pulse
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b1);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        // test plan 6: exhaustive din/sel/rst_n
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < 2; d++)
                for (int s = 0; s < 2; s++)
                    step(r[0], {7'b0, d[0]}, s[0], 1'b0);
        // randomized traffic with occasional resets and pulses
        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic       p;
            r = ($urandom_range(0, 15) != 0);
            p = r && ($urandom_range(0, 15) == 0);
            step(r, 8'($urandom), 1'($urandom), p);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmux.md
# dmux

One-input, two-output demultiplexer. It routes data input `din` to output `y0` or `y1` according to select `sel`, and drives the non-selected output to the idle value. The block is a small routing primitive for steering a single source into one of two downstream consumers. The default build is combinational with an asynchronous reset gate; a parameter adds an optional registered output stage.

## Interface
Parameters:
- `WIDTH`, default 1: bit width of `din`, `y0` and `y1`.
- `REGISTERED`, default 0: 0 selects combinational outputs; 1 selects outputs registered on `clk`.
- `IDLE_VALUE`, default 0 (all bits): value driven on the non-selected output and on both outputs during reset.

Ports:
- `clk` input 1: single clock. Used only when `REGISTERED`=1.
- `rst_n` input 1: reset. **Asynchronous and active-low.**
- `din` input WIDTH: data to route.
- `sel` input 1: output select. 0 selects `y0`; 1 selects `y1`.
- `y0` output WIDTH: equals `din` when `sel`=0, otherwise `IDLE_VALUE`.
- `y1` output WIDTH: equals `din` when `sel`=1, otherwise `IDLE_VALUE`.

## Operation
Routing rule, with `rst_n`=1:
- When `sel`=0: `y0`=`din` and `y1`=`IDLE_VALUE`.
- When `sel`=1: `y1`=`din` and `y0`=`IDLE_VALUE`.
- Exactly one output carries `din` at any time.
- With the default `IDLE_VALUE`=0 and WIDTH=1, the outputs reduce to `y0` = `din` & ~`sel` and `y1` = `din` & `sel`.

Reset:
- While `rst_n`=0, both `y0` and `y1` equal `IDLE_VALUE`, in both modes.

X/Z handling:
- `sel` at X/Z must not produce a spurious `din` copy on both outputs.
- In simulation, both outputs go to X in that case.
- No state is kept in combinational mode.

REGISTERED=1 mode:
- A `y0`/`y1` register pair captures the routing rule on each rising edge of `clk`.
- No enable and no extra internal state.

## Timing
REGISTERED=0:
- Zero-cycle combinational path from `din`/`sel` to `y0`/`y1`. The outputs track the inputs within the same delta/time step.
- Assertion of `rst_n` forces the outputs to `IDLE_VALUE` immediately, independent of `clk`.
- Deassertion of `rst_n` restores routing immediately.

REGISTERED=1:
- Latency is one cycle. The outputs reflect `din`/`sel` sampled at the previous rising `clk` edge.
- Reset asserts asynchronously: the outputs go to `IDLE_VALUE` with no clock edge needed.
- Deassertion is synchronized by the integrator. The first capture occurs at the first rising edge with `rst_n`=1.

Boundary conditions:
- Reset asserted mid-operation: the outputs drop to `IDLE_VALUE` at once, and no partial value remains.
- `sel` and `din` changing together: the outputs reflect the new pair. In combinational mode, no glitch on the non-selected output is required beyond normal gate hazards.
- Reset asserted on the same edge as a capture: reset wins.

## Test plan
1. Default parameters, `rst_n`=1. Apply this sequence, each step held 10 ns:
   - (`din`,`sel`) = (0,0) → `y0`=0, `y1`=0.
   - (1,0) → `y0`=1, `y1`=0.
   - (1,1) → `y0`=0, `y1`=1.
   - (0,1) → `y0`=0, `y1`=0.
   - (1,0) → `y0`=1, `y1`=0.
   - (0,0) → `y0`=0, `y1`=0.
2. Default parameters, `din`=1, `sel`=1, then `rst_n` driven to 0 → `y0`=`y1`=0 immediately. Release `rst_n` → `y1`=1 again.
3. `WIDTH`=8, `din`=8'hA5:
   - `sel`=0 → `y0`=8'hA5, `y1`=8'h00.
   - `sel`=1 → `y0`=8'h00, `y1`=8'hA5.
4. `WIDTH`=4, `IDLE_VALUE`=4'hF, `din`=4'h3, `sel`=1 → `y0`=4'hF, `y1`=4'h3. Then `rst_n`=0 → both outputs 4'hF.
5. `REGISTERED`=1, 10 ns clock:
   - `din`=1, `sel`=0 applied before an edge → `y0` rises only after that rising edge.
   - `rst_n` pulsed low between edges → both outputs clear without a clock edge.
6. Exhaustive check: every (`din`,`sel`) combination with `rst_n` ∈ {0,1} is checked against the routing rule, with no output mismatch.
